// File: rtl/pager_seq_detect.sv
// Serial page-code detector: matches a loadable CODE_W-bit code in bit stream x, counts pages.
// Latency: z is registered and rises in the cycle after the edge that samples the completing bit.
// Backpressure: none; x is consumed only on en=1 edges, and code_ld overrides en.
module pager_seq_detect #(
   parameter int                CODE_W   = 4,
   parameter logic [CODE_W-1:0] CODE_RST = 4'b0011,
   parameter bit                OVERLAP  = 1'b1,
   parameter bit                LATCH    = 1'b0,
   parameter int                CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              x,
   input  logic              code_ld,
   input  logic [CODE_W-1:0] code_in,
   input  logic              ack,
   output logic              z,
   output logic [CNT_W-1:0]  page_cnt,
   output logic              armed
);

   localparam int                FILL_W  = $clog2(CODE_W + 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(CODE_W);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   // ARMED means the history holds CODE_W valid bits; it always tracks fill == CODE_W
   typedef enum logic {
      FILLING = 1'b0,
      ARMED   = 1'b1
   } state_t;

   state_t              state_q, state_n;
   logic [CODE_W-1:0]   hist_q, hist_n, hist_sh;
   logic [FILL_W-1:0]   fill_q, fill_n, fill_inc;
   logic [CODE_W-1:0]   code_q, code_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic                z_q, z_n;
   logic                match;

   // State register: reset restores the power-on code and clears everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILLING;
         hist_q  <= '0;
         fill_q  <= '0;
         code_q  <= CODE_RST;
         cnt_q   <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_n;
         hist_q  <= hist_n;
         fill_q  <= fill_n;
         code_q  <= code_n;
         cnt_q   <= cnt_n;
         z_q     <= z_n;
      end
   end

   // Next-state: shift/compare on enabled samples, code load restarts the history
   always_comb begin
      hist_n   = hist_q;
      fill_n   = fill_q;
      code_n   = code_q;
      cnt_n    = cnt_q;
      match    = 1'b0;
      hist_sh  = {hist_q[CODE_W-2:0], x};
      fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;

      if (code_ld) begin
         // x is dropped on a load edge; a partial history can never match
         code_n = code_in;
         hist_n = '0;
         fill_n = '0;
      end else if (en) begin
         match  = (fill_inc == FULL) && (hist_sh == code_q);
         hist_n = hist_sh;
         fill_n = fill_inc;
         if (match && !OVERLAP) begin
            hist_n = '0;
            fill_n = '0;
         end
      end

      if (match && (cnt_q != CNT_MAX)) begin
         cnt_n = cnt_q + 1'b1;
      end

      // Pulse mode follows match directly; latch mode sets on match (winning over ack)
      if (LATCH) begin
         if (match)    z_n = 1'b1;
         else if (ack) z_n = 1'b0;
         else          z_n = z_q;
      end else begin
         z_n = match;
      end

      state_n = (fill_n == FULL) ? ARMED : FILLING;
   end

   assign z        = z_q;
   assign page_cnt = cnt_q;
   assign armed    = (state_q == ARMED);

endmodule
